// File: rtl/game_flow_pkg.sv
// Shared types and constants for the game sequencer: FSM state encoding,
// datapath "finished" status codes and the score width.
package game_flow_pkg;

    localparam int SCORE_W = 14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        CLEAR = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } game_state_t;

    // Codes 3..7 are reserved and fall through as FIN_RUN
    localparam logic [2:0] FIN_RUN   = 3'd0;
    localparam logic [2:0] FIN_CLEAR = 3'd1;
    localparam logic [2:0] FIN_LOST  = 3'd2;

endpackage

// File: rtl/btn_edge_det.sv
// Registers a synchronous, debounced button level and emits a one-cycle pulse
// on its rising edge, so a held button produces exactly one event.
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic btn_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_p1 <= 1'b0;
        end else begin
            btn_p1 <= btn;
        end
    end

    assign rise = btn & ~btn_p1;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: FSM, frame counter and score/high-score datapath.
// Optional pause support is compiled in when GAME_PAUSE_EN is defined.
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int MAX_SCORE    = 9999,
    parameter int OVER_FRAMES  = 120,
    parameter int CLEAR_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic [2:0]         finished,
    input  logic [1:0]         plus_score,
    output logic               enable_game,
    output logic               freeze,
    output logic               show_game_start,
    output logic               show_game_over,
    output logic               game_clr,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam int FRAME_MAX = (OVER_FRAMES > CLEAR_FRAMES) ? OVER_FRAMES : CLEAR_FRAMES;
    localparam int FCNT_W    = $clog2(FRAME_MAX + 1);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [1:0]         b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {{(SCORE_W - 1){1'b0}}, b};
        if (sum > (SCORE_W + 1)'(MAX_SCORE)) begin
            sat_add = SCORE_W'(MAX_SCORE);
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    game_state_t        state, state_next;
    logic               clr_next;
    logic               start_rise;
    logic               pause_rise;
    logic [FCNT_W-1:0]  frame_cnt;
    logic [FCNT_W-1:0]  frame_target;
    logic               frame_done;
    logic               score_live;
    logic [SCORE_W-1:0] score_upd;

    btn_edge_det u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_start),
        .rise  (start_rise)
    );

`ifdef GAME_PAUSE_EN
    btn_edge_det u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_pause),
        .rise  (pause_rise)
    );
`else
    logic unused_btn_pause;
    assign unused_btn_pause = btn_pause;
    assign pause_rise       = 1'b0;
`endif

    assign frame_target = (state == OVER) ? FCNT_W'(OVER_FRAMES) : FCNT_W'(CLEAR_FRAMES);
    assign frame_done   = (frame_cnt == frame_target);
    assign score_live   = (state == PLAY) || (state == CLEAR);
    assign score_upd    = score_live ? sat_add(score, plus_score) : score;

    // Next-state logic; finished status takes priority over a pause request
    always_comb begin
        state_next = state;
        clr_next   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise) begin
                    state_next = PLAY;
                    clr_next   = 1'b1;
                end
            end
            PLAY: begin
                if (finished == FIN_LOST) begin
                    state_next = OVER;
                end else if (finished == FIN_CLEAR) begin
                    state_next = CLEAR;
                end else if (pause_rise) begin
                    state_next = PAUSE;
                end
            end
            CLEAR: begin
                if (frame_done) begin
                    state_next = PLAY;
                    clr_next   = 1'b1;
                end
            end
            PAUSE: begin
                if (pause_rise) begin
                    state_next = PLAY;
                end
            end
            OVER: begin
                if (frame_done && start_rise) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output register: decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_game     <= 1'b0;
            freeze          <= 1'b0;
            show_game_start <= 1'b1;
            show_game_over  <= 1'b0;
            game_clr        <= 1'b0;
        end else begin
            enable_game     <= (state_next == PLAY) || (state_next == CLEAR) ||
                               (state_next == PAUSE);
            freeze          <= (state_next != PLAY);
            show_game_start <= (state_next == IDLE);
            show_game_over  <= (state_next == OVER);
            game_clr        <= clr_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (state_next != state) begin
            frame_cnt <= '0;
        end else if (frame_tick && ((state == CLEAR) || (state == OVER)) && !frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Points arriving on the losing cycle are included before the high-score compare
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score      <= '0;
            high_score <= '0;
        end else begin
            if ((state == IDLE) && (state_next == PLAY)) begin
                score <= '0;
            end else begin
                score <= score_upd;
            end
            if ((state != OVER) && (state_next == OVER) && (score_upd > high_score)) begin
                high_score <= score_upd;
            end
        end
    end

endmodule
